// File: rtl/booth_mult8_sequencer.sv
// booth_mult8_sequencer
// ---------------------------------------------------------------------------
// Issue/return controller that sits in front of the 8-bit Booth multiplier.
// Operand requests are buffered in a small FIFO. One operation at a time is
// issued to the multiplier as a start pulse with stable registered operands.
// The product is captured on the rising edge of mul_done and presented on a
// valid/ready result port.
//
// Optional feature macro: BOOTH_SEQ_TIMEOUT_EN
//   When defined, an 8-bit watchdog forces a zero result with out_timeout=1
//   if no done event arrives within TIMEOUT cycles of WAIT.
//   When undefined, WAIT persists until a done event and out_timeout is 0.
//
// Parameters:
//   DEPTH   - request FIFO entries (power of two, >= 2)
//   TIMEOUT - watchdog limit in WAIT cycles (1..255), watchdog build only
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               request handshake (in_ready = FIFO not full)
//   in_a, in_b, in_sign_mode        request operands and sign mode
//   mul_start                       one-cycle start pulse to the multiplier
//   mul_multiplicand/mul_multiplier registered operands, held during WAIT
//   mul_sign_mode                   registered sign mode
//   mul_product, mul_done           multiplier result and completion
//   out_valid/out_ready             result handshake
//   out_product, out_timeout        captured product, watchdog flag
//   busy                            operation in flight or FIFO non-empty
// ---------------------------------------------------------------------------
module booth_mult8_sequencer #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [1:0]  in_sign_mode,
  output logic        mul_start,
  output logic [7:0]  mul_multiplicand,
  output logic [7:0]  mul_multiplier,
  output logic [1:0]  mul_sign_mode,
  input  logic [15:0] mul_product,
  input  logic        mul_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_product,
  output logic        out_timeout,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  if ((DEPTH < 32'sd2) || ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0) ||
      (TIMEOUT < 32'sd1) || (TIMEOUT > 32'sd255)) begin : g_bad_params
    $error("booth_mult8_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT within 1..255");
  end

  logic [17:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [1:0]    state_r;
  logic          mul_done_q_r;

  logic          push_s;
  logic          pop_s;
  logic          done_evt_s;
  logic          wdog_hit_s;
  logic [17:0]   head_s;

  // in_ready depends on the registered count only, never on in_valid.
  assign in_ready = (count_r != CNT_FULL);
  assign busy     = (state_r != ST_IDLE) || (count_r != CNT_ZERO);

  // Handshake qualifiers, done edge detect and FIFO head decode.
  always_comb begin
    push_s     = in_valid & in_ready;
    pop_s      = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
    done_evt_s = mul_done & ~mul_done_q_r;
    head_s     = mem_r[rd_ptr_r];
  end

  // Registered copy of mul_done so a level-held done yields a single event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_done_q_r <= 1'b0;
    end else begin
      mul_done_q_r <= mul_done;
    end
  end

  // Request FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 18'h00000;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {in_sign_mode, in_b, in_a};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue/return state machine with registered operand and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      mul_start        <= 1'b0;
      mul_multiplicand <= 8'h00;
      mul_multiplier   <= 8'h00;
      mul_sign_mode    <= 2'b00;
      out_valid        <= 1'b0;
      out_product      <= 16'h0000;
    end else begin
      mul_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            mul_multiplicand <= head_s[7:0];
            mul_multiplier   <= head_s[15:8];
            mul_sign_mode    <= head_s[17:16];
            mul_start        <= 1'b1;
            state_r          <= ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // A real done event wins over a watchdog expiry in the same cycle.
          if (done_evt_s) begin
            out_product <= mul_product;
            out_valid   <= 1'b1;
            state_r     <= ST_RESP;
          end else if (wdog_hit_s) begin
            out_product <= 16'h0000;
            out_valid   <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BOOTH_SEQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [7:0] wdog_r;

  // Expiry is flagged on the WAIT cycle whose increment would reach TIMEOUT.
  assign wdog_hit_s = (state_r == ST_WAIT) && ((wdog_r + 8'h01) == TIMEOUT_C);

  // Watchdog: cleared when an operation is issued, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_r <= 8'h00;
    end else if (pop_s) begin
      wdog_r <= 8'h00;
    end else if (state_r == ST_WAIT) begin
      wdog_r <= wdog_r + 8'h01;
    end else begin
      wdog_r <= wdog_r;
    end
  end

  // Timeout flag travels with the result and holds through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_timeout <= 1'b0;
    end else if ((state_r == ST_WAIT) && done_evt_s) begin
      out_timeout <= 1'b0;
    end else if (wdog_hit_s) begin
      out_timeout <= 1'b1;
    end else begin
      out_timeout <= out_timeout;
    end
  end
`else
  assign wdog_hit_s  = 1'b0;
  assign out_timeout = 1'b0;
`endif

endmodule

// File: doc/booth_mult8_sequencer.md
# booth_mult8_sequencer

Upstream issue/return controller for the 8-bit Booth multiplier. It accepts operand requests on a valid/ready stream and buffers them in a small FIFO. It issues one operation at a time to the multiplier's registered input stage (start pulse plus stable operands), then captures the product on the multiplier's done. The result is presented on a valid/ready output with optional watchdog timeout.

## Interface
Parameters:
- DEPTH, 2: request FIFO entries; power of two, ≥2.
- TIMEOUT, 31: maximum WAIT cycles before forced completion; used only with the timeout feature; range 1–255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready at posedge; equals FIFO not full.
- in_a  in  8  multiplicand.
- in_b  in  8  multiplier.
- in_sign_mode  in  2  sign mode, passed through unmodified.
- mul_start  out  1  one-cycle start pulse to multiplier.
- mul_multiplicand  out  8  registered operand.
- mul_multiplier  out  8  registered operand.
- mul_sign_mode  out  2  registered sign mode.
- mul_product  in  16  multiplier result.
- mul_done  in  1  multiplier completion; pulse or level.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready at posedge.
- out_product  out  16  captured product.
- out_timeout  out  1  result was forced by watchdog; tied 0 without the macro.
- busy  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- FIFO: DEPTH × 18 bits {sign_mode, b, a}. Pointer width is log2(DEPTH); count width is log2(DEPTH)+1. Pointers wrap. Push on in_valid & in_ready. Pop only from IDLE, using the registered count.
- mul_done_q: mul_done registered every cycle. A done event is mul_done & ~mul_done_q. Level-held done yields exactly one event.
- States:
  - IDLE: if count ≠ 0, pop the head. Load mul_multiplicand, mul_multiplier and mul_sign_mode; set mul_start=1; go to WAIT.
  - WAIT: mul_start=0. Operands hold. On a done event, set out_product ← mul_product, out_valid ← 1, out_timeout ← 0; go to RESP. Done events in any other state are ignored.
  - RESP: hold out_valid, out_product and out_timeout. On out_valid & out_ready, clear out_valid and go to IDLE.
- At most one operation is outstanding. Results come out in request order.
- Simultaneous push and pop in IDLE: both occur; count is unchanged.
- Full FIFO: in_ready=0. Requests are never dropped or overwritten.
- Reset values (async): state IDLE, FIFO pointers and count 0, in_ready 1, mul_start 0, mul_* operands 0, out_valid 0, out_product 0, out_timeout 0, busy 0, mul_done_q 0, watchdog counter 0.
- Reset mid-operation: the in-flight operation and all FIFO contents are discarded. A late mul_done afterwards is ignored, because the state is IDLE.

## Timing
- Request accepted at edge E0 into an empty FIFO, with the sequencer in IDLE: pop at E1; mul_start high for the cycle after E1 only.
- The multiplier adds its own latency L, measured from start to done, including its isolation register.
- Done event sampled at edge Ed: out_valid high from Ed.
- Minimum period per operation: 2 + L + 1 cycles, plus any out_ready stall.
- in_ready is combinational from count only; there is no combinational path from in_valid or out_ready.

## Configuration
- BOOTH_SEQ_TIMEOUT_EN defined:
  - An 8-bit watchdog clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no done event: out_product ← 16'h0000, out_timeout ← 1, out_valid ← 1; go to RESP.
  - A done event in the same cycle as the timeout takes priority, giving a normal result.
- Not defined:
  - WAIT persists until a done event.
  - out_timeout is constant 0 and the watchdog logic is absent.

## Test plan
The bench pairs the DUT with a multiplier stub: latency L=10, product = signed(a)·signed(b), done a one-cycle pulse unless stated otherwise.
- Single op, a=8'h05, b=8'hFD, sign_mode=2'b11 -> exactly one mul_start pulse; operands stable until done; out_product=16'hFFF1 with out_valid one cycle after done; out_timeout=0.
- Three back-to-back requests (7×3, −8×−8, 127×−128) with DEPTH=2 and out_ready=0 -> in_ready falls after the third accept; then release out_ready -> outputs 16'h0015, 16'h0040, 16'hC080 in order, no loss.
- Stub holds mul_done high for 5 cycles -> exactly one capture; the next request is not spuriously completed.
- Assert rst_n low 4 cycles into WAIT with 1 request queued, then stub asserts done -> all outputs return to reset values; out_valid stays 0; FIFO empty.
- Stub never asserts done, TIMEOUT=31 -> with BOOTH_SEQ_TIMEOUT_EN: out_valid=1, out_timeout=1, out_product=0 after 31 WAIT cycles, and the next request proceeds normally; without the macro: out_valid stays 0 for 200 cycles and busy=1.
- in_valid pulsed in the same cycle as an IDLE pop, FIFO at count 1 -> count stays 1; no request is duplicated or lost.
